// File: rtl/ctrl_word_sequencer_if.sv
// Handshake and instruction-memory bundle between the LU control-word sequencer and its surroundings.
// The cycle_count signal exists only when CTRL_SEQ_CYCLE_COUNT_EN is defined.
interface ctrl_word_sequencer_if #(
   parameter int CTRL_WIDTH = 72,
   parameter int PC_WIDTH   = 12
);
   logic                  start;
   logic [PC_WIDTH-1:0]   base_addr;
   logic                  hold;
   logic                  imem_en;
   logic [PC_WIDTH-1:0]   imem_addr;
   logic [CTRL_WIDTH-1:0] imem_dout;
   logic [CTRL_WIDTH-1:0] CTRL_Signal;
   logic                  busy;
   logic                  done;
   logic                  overrun;
`ifdef CTRL_SEQ_CYCLE_COUNT_EN
   logic [31:0]           cycle_count;
`endif

   // The master is the controller/BRAM side; the slave is the sequencer itself.
   modport master (
      output start, base_addr, hold, imem_dout,
      input  imem_en, imem_addr, CTRL_Signal, busy, done, overrun
`ifdef CTRL_SEQ_CYCLE_COUNT_EN
      , input cycle_count
`endif
   );

   modport slave (
      input  start, base_addr, hold, imem_dout,
      output imem_en, imem_addr, CTRL_Signal, busy, done, overrun
`ifdef CTRL_SEQ_CYCLE_COUNT_EN
      , output cycle_count
`endif
   );
endinterface

// File: rtl/ctrl_word_sequencer.sv
// Streams control words from the instruction BRAM to the LU datapath, one per cycle, until a word with bit 0 set.
// Optional feature macro: CTRL_SEQ_CYCLE_COUNT_EN adds a saturating 32-bit busy-cycle counter.
module ctrl_word_sequencer #(
   parameter int CTRL_WIDTH = 72,
   parameter int PC_WIDTH   = 12
) (
   input logic               CLK_100,
   input logic               RST,
   ctrl_word_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [PC_WIDTH-1:0] PC_TOP = {PC_WIDTH{1'b1}};

   state_t                state_q;
   logic [PC_WIDTH-1:0]   pc_q;
   logic [PC_WIDTH-1:0]   pc_d;
   logic                  v1_q;
   logic                  lastFetch_q;
   logic [CTRL_WIDTH-1:0] ctrl_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  overrun_q;
   logic                  fetchEn;
   logic                  emit;
   logic                  endOfRun;

   // A fetch at the top address marks the last word; pc stays put so it never wraps.
   assign fetchEn  = (state_q == FETCH) && !lastFetch_q && !bus.hold;
   assign emit     = (state_q == FETCH) && v1_q && !bus.hold;
   assign endOfRun = bus.imem_dout[0] || lastFetch_q;
   assign pc_d     = (pc_q == PC_TOP) ? pc_q : pc_q + 1'b1;

   // Sequencer FSM: every datapath-facing output is registered here and defaults to a NOP word.
   always_ff @(posedge CLK_100 or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         v1_q        <= 1'b0;
         lastFetch_q <= 1'b0;
         ctrl_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         ctrl_q <= '0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  pc_q        <= bus.base_addr;
                  v1_q        <= 1'b0;
                  lastFetch_q <= 1'b0;
                  busy_q      <= 1'b1;
                  overrun_q   <= 1'b0;
                  state_q     <= FETCH;
               end
            end
            FETCH: begin
               if (fetchEn) begin
                  v1_q <= 1'b1;
                  pc_q <= pc_d;
                  if (pc_q == PC_TOP) begin
                     lastFetch_q <= 1'b1;
                  end
               end
               // While hold is high the BRAM output is frozen, so the pending word is emitted on release.
               if (emit) begin
                  ctrl_q <= bus.imem_dout;
                  if (endOfRun) begin
                     overrun_q <= !bus.imem_dout[0];
                     state_q   <= DONE;
                  end
               end
            end
            DONE: begin
               done_q      <= 1'b1;
               busy_q      <= 1'b0;
               v1_q        <= 1'b0;
               lastFetch_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef CTRL_SEQ_CYCLE_COUNT_EN
   logic [31:0] cycleCount_q;

   // Counts every cycle with busy high, hold cycles included, and sticks at all-ones.
   always_ff @(posedge CLK_100 or posedge RST) begin
      if (RST) begin
         cycleCount_q <= '0;
      end else if ((state_q == IDLE) && bus.start) begin
         cycleCount_q <= '0;
      end else if (busy_q && (cycleCount_q != 32'hFFFF_FFFF)) begin
         cycleCount_q <= cycleCount_q + 32'd1;
      end
   end

   assign bus.cycle_count = cycleCount_q;
`endif

   assign bus.imem_en     = fetchEn;
   assign bus.imem_addr   = pc_q;
   assign bus.CTRL_Signal = ctrl_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_ctrl_word_sequencer.sv
// Self-checking bench for ctrl_word_sequencer: directed programs plus randomized holds/starts against a stream-level model.
module tb_ctrl_word_sequencer;

   localparam int CW = 72;
   localparam int PW = 12;

   logic CLK_100 = 1'b0;
   logic RST;
   int   compareCount  = 0;
   int   mismatchCount = 0;
   logic [CW-1:0] mem [0:4095];

   ctrl_word_sequencer_if #(.CTRL_WIDTH(CW), .PC_WIDTH(PW)) bus ();

   ctrl_word_sequencer #(.CTRL_WIDTH(CW), .PC_WIDTH(PW)) dut (
      .CLK_100 (CLK_100),
      .RST     (RST),
      .bus     (bus.slave)
   );

   always #5 CLK_100 = ~CLK_100;

   // Instruction BRAM: output register only updates on an enabled read.
   always @(posedge CLK_100) begin
      if (bus.imem_en) bus.imem_dout <= mem[bus.imem_addr];
   end

   function automatic logic [CW-1:0] ext1(input logic b);
      logic [CW-1:0] r;
      r = '0;
      r[0] = b;
      return r;
   endfunction

   function automatic logic [CW-1:0] randWord();
      logic [95:0]   r;
      logic [CW-1:0] w;
      r = {$urandom, $urandom, $urandom};
      w = r[CW-1:0];
      w[4] = 1'b1;
      w[0] = 1'b0;
      return w;
   endfunction

   task automatic checkOutput(input string tag, input logic [CW-1:0] observed, input logic [CW-1:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic loadProgram(input int base, input int len);
      logic [CW-1:0] w;
      for (int i = 0; i < len; i++) begin
         if (base + i > 4095) break;
         w = randWord();
         if (i == len - 1) w[0] = 1'b1;
         mem[base + i] = w;
      end
   endtask

   // Model: from the start edge the first non-held edge fills the pipeline, each later non-held
   // edge emits the next program word, and the edge after the last word is the done edge.
   task automatic applyStimulus(input logic [PW-1:0] base, input logic [63:0] holdMask,
                                input int holdPct, input int startPct);
      logic [CW-1:0] expWords[$];
      logic [CW-1:0] expCtrl;
      logic          expOverrun;
      logic          filled;
      logic          finished;
      logic          h;
      int            addr;
      int            emitted;
      int            budget;
      int            k;
      int            doneEdge;

      addr = int'(base);
      expOverrun = 1'b0;
      while (1) begin
         expWords.push_back(mem[addr]);
         if (mem[addr][0]) break;
         if (addr == 4095) begin
            expOverrun = 1'b1;
            break;
         end
         addr++;
      end
      budget = expWords.size() * 10 + 64;

      @(negedge CLK_100);
      bus.start     = 1'b1;
      bus.base_addr = base;
      bus.hold      = 1'b0;
      @(posedge CLK_100);
      #1;
      checkOutput("startBusy", ext1(bus.busy), ext1(1'b1));
      checkOutput("startCtrl", bus.CTRL_Signal, '0);
      checkOutput("startAddr", CW'(bus.imem_addr), CW'(base));
      checkOutput("startOverrunClear", ext1(bus.overrun), ext1(1'b0));

      emitted  = 0;
      filled   = 1'b0;
      finished = 1'b0;
      doneEdge = 0;
      k        = 0;
      while (!finished && k < budget) begin
         k++;
         @(negedge CLK_100);
         h = ((k < 64) && holdMask[k[5:0]]) || ($urandom_range(99) < holdPct);
         bus.hold  = h;
         bus.start = ($urandom_range(99) < startPct);
         @(posedge CLK_100);
         #1;
         if (emitted == expWords.size()) begin
            finished = 1'b1;
            doneEdge = k;
            checkOutput("doneCtrl", bus.CTRL_Signal, '0);
            checkOutput("donePulse", ext1(bus.done), ext1(1'b1));
            checkOutput("doneBusy", ext1(bus.busy), ext1(1'b0));
            checkOutput("doneOverrun", ext1(bus.overrun), ext1(expOverrun));
            checkOutput("doneImemEn", ext1(bus.imem_en), ext1(1'b0));
         end else begin
            expCtrl = '0;
            if (!h) begin
               if (!filled) begin
                  filled = 1'b1;
               end else begin
                  expCtrl = expWords[emitted];
                  emitted++;
               end
            end
            checkOutput("ctrlWord", bus.CTRL_Signal, expCtrl);
            checkOutput("runBusy", ext1(bus.busy), ext1(1'b1));
            checkOutput("runDone", ext1(bus.done), ext1(1'b0));
         end
      end
      if (!finished) checkOutput("timeout", ext1(1'b0), ext1(1'b1));
`ifdef CTRL_SEQ_CYCLE_COUNT_EN
      checkOutput("cycleCount", CW'(bus.cycle_count), CW'(doneEdge));
`endif

      @(negedge CLK_100);
      bus.start = 1'b0;
      bus.hold  = 1'b0;
      @(posedge CLK_100);
      #1;
      checkOutput("postDone", ext1(bus.done), ext1(1'b0));
      checkOutput("postBusy", ext1(bus.busy), ext1(1'b0));
      checkOutput("postCtrl", bus.CTRL_Signal, '0);
   endtask

   initial begin
      RST           = 1'b1;
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.hold      = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = randWord();

      repeat (2) @(posedge CLK_100);
      #1;
      checkOutput("rstCtrl", bus.CTRL_Signal, '0);
      checkOutput("rstBusy", ext1(bus.busy), ext1(1'b0));
      checkOutput("rstDone", ext1(bus.done), ext1(1'b0));
      checkOutput("rstOverrun", ext1(bus.overrun), ext1(1'b0));
      checkOutput("rstImemEn", ext1(bus.imem_en), ext1(1'b0));
      checkOutput("rstAddr", CW'(bus.imem_addr), '0);
      @(negedge CLK_100);
      RST = 1'b0;

      $display("[TB] three-word program at 0x010");
      mem[16] = {64'h0123_4567_89AB_CDEF, 8'hA0};
      mem[17] = {64'h1122_3344_5566_7788, 8'hB0};
      mem[18] = {64'h99AA_BBCC_DDEE_FF00, 8'hC1};
      applyStimulus(12'h010, 64'h0, 0, 0);
      applyStimulus(12'h010, 64'h38, 0, 0);
      applyStimulus(12'h010, 64'h0, 0, 100);

      $display("[TB] single-word program at 0x000");
      mem[0] = randWord() | 72'h1;
      mem[1] = randWord();
      applyStimulus(12'h000, 64'h0, 0, 0);

      $display("[TB] overrun at top of memory");
      mem[4094] = randWord();
      mem[4095] = randWord();
      applyStimulus(12'hFFE, 64'h0, 0, 0);
      applyStimulus(12'h010, 64'h0, 0, 0);

      $display("[TB] reset in the middle of a ten-word program");
      loadProgram(256, 10);
      @(negedge CLK_100);
      bus.start     = 1'b1;
      bus.base_addr = 12'h100;
      @(negedge CLK_100);
      bus.start = 1'b0;
      repeat (4) @(posedge CLK_100);
      #1;
      checkOutput("preResetWord", bus.CTRL_Signal, mem[258]);
      #2;
      RST = 1'b1;
      #1;
      checkOutput("midRstCtrl", bus.CTRL_Signal, '0);
      checkOutput("midRstBusy", ext1(bus.busy), ext1(1'b0));
      checkOutput("midRstDone", ext1(bus.done), ext1(1'b0));
      checkOutput("midRstImemEn", ext1(bus.imem_en), ext1(1'b0));
      @(negedge CLK_100);
      RST = 1'b0;
      applyStimulus(12'h100, 64'h0, 0, 0);

      $display("[TB] randomized programs with holds and stray starts");
      for (int n = 0; n < 24; n++) begin
         int base;
         base = int'($urandom_range(4095, 0));
         loadProgram(base, int'($urandom_range(8, 1)));
         applyStimulus(PW'(base), 64'h0, 30, 20);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/ctrl_word_sequencer.md
Name: ctrl_word_sequencer

Overview:
- Upstream stage of the LU-decomposition datapath. Streams precomputed control words from an instruction BRAM and presents one word per cycle on CTRL_Signal.
- Each word carries BRAM addresses, write enables, AU selects and BRAM-input selects for the datapath.
- Bit 0 of a word is the "complete" flag and terminates the program.
- Provides start/busy/done handshake, hold (stall) and overrun detection.

Parameters:
- CTRL_WIDTH, 72, width of one control word.
- PC_WIDTH, 12, instruction-memory address width.

Ports:
- CLK_100  in  1  system clock; all logic rising-edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a program run from base_addr when idle.
- base_addr  in  PC_WIDTH  first instruction address; sampled with start.
- hold  in  1  stall request; freezes sequencing while high.
- imem_en  out  1  instruction BRAM enable.
- imem_addr  out  PC_WIDTH  instruction BRAM address; equals pc.
- imem_dout  in  CTRL_WIDTH  instruction BRAM data; valid one cycle after an enabled address.
- CTRL_Signal  out  CTRL_WIDTH  registered control word to the datapath.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the run ends.
- overrun  out  1  sticky flag: pc hit the top address without a terminator; cleared by the next accepted start.

Behaviour:
Reset:
- Asynchronous assertion forces all of the following at once: state=IDLE, pc=0, fetch-valid v1=0, CTRL_Signal=0, imem_en=0, busy=0, done=0, overrun=0.
- Reset mid-run aborts immediately. No words are emitted afterwards.

States:
- IDLE
  - start=1 → pc<=base_addr, busy<=1, overrun<=0, go FETCH.
  - start while not IDLE is ignored.
- FETCH
  - imem_en = !hold.
  - On each enabled cycle: pc<=pc+1, v1<=1.
  - Pipeline stage 2: if v1 && !hold then CTRL_Signal<=imem_dout, else CTRL_Signal<=0 (NOP word; every we=0, every sel=0).
  - While hold=1: pc, v1 and BRAM output are frozen because imem_en=0. On release, the frozen word is emitted, so no word is lost or duplicated.
  - When v1 && !hold && imem_dout[0]=1: emit that word, then stop fetching (imem_en<=0), go DONE. The word fetched speculatively after the terminator is discarded.
  - When an enabled fetch occurs at pc=all-ones and the word there is not a terminator: set overrun=1, stop fetching, go DONE after emitting that word.
- DONE
  - One cycle: CTRL_Signal=0, done=1, busy<=0, v1<=0, go IDLE.
  - hold is ignored in DONE.

Latency and counts:
- start sampled at edge E0 → imem_addr=base_addr after E0.
- CTRL_Signal=word[base] after E2; word[base+k] after E2+k (no hold).
- Each hold cycle adds exactly one NOP cycle.
- done asserts the cycle after the terminator word is on CTRL_Signal.
- Program of N words, no hold: busy high N+2 cycles.

Outside a run:
- CTRL_Signal is all-zero whenever not emitting a fetched word. IDLE, DONE, hold and pipeline-fill cycles are all zero.

Arithmetic:
- pc is unsigned and never wraps during a run; the overrun rule stops it at the top address.

Optional Feature:
- Macro CTRL_SEQ_CYCLE_COUNT_EN.
- Defined:
  - Adds output cycle_count (32 bits, reset 0).
  - Clears on accepted start; increments every busy cycle, including hold cycles.
  - Saturates at all-ones and holds its value after done.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Program at 0x010: words W0=0x..A0, W1=0x..B0, W2=0x..C1 (terminator). Pulse start with base_addr=0x010 → CTRL_Signal=W0,W1,W2 on cycles 2,3,4 after start; 0 on cycle 5; done=1 on cycle 5; busy high cycles 1–5.
- Same program with hold=1 for 3 cycles while W1 is pending → CTRL_Signal=W0,0,0,0,W1,W2; W1 appears exactly once; done is 3 cycles later than the no-hold case.
- Single-word program, terminator at base_addr=0x000 → one word emitted, then done. The speculative word at 0x001 never appears on CTRL_Signal.
- No terminator, base_addr=0xFFE → words at 0xFFE and 0xFFF emitted, overrun=1, done pulse. Next start clears overrun.
- Assert RST for 1 cycle during word 3 of a 10-word program → CTRL_Signal, busy and done go 0 immediately. A new start reruns the program from word 0 with normal latency.
- start pulsed again while busy → ignored; sequence and done timing unchanged. With CTRL_SEQ_CYCLE_COUNT_EN, the 3-word run gives cycle_count=5.
